// File: rtl/alu_ctrl_mdu.sv
`default_nettype none
// ==== alu_ctrl_mdu : ALU_Control decode + iterative mult/div unit with HI/LO and stall. Rev 1.0 ====
// ==== Divider datapath is built only when ALU_CTRL_MDU_DIV_EN is defined.                      ====
module alu_ctrl_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Function,
  input  logic             valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       ALU_Control,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SIGN = 2'd2} state_t;
  state_t state, state_nxt;

  logic                 is_mul, is_div, accept, uns;
  logic                 a_neg, b_neg, res_neg;
  logic [WIDTH-1:0]     a_abs, b_abs, b_mag;
  logic [2*WIDTH-1:0]   acc, acc_nxt, prod;
  logic [WIDTH:0]       mul_sum;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     res_hi, res_lo;
  logic                 res_dz;

  always_comb begin
    ALU_Control = 4'b0000;
    case (ALUOp)
      2'b00: ALU_Control = 4'b0010;
      2'b01: ALU_Control = 4'b0110;
      2'b10: begin
        case (Function)
          6'b100100:           ALU_Control = 4'b0000;
          6'b100101:           ALU_Control = 4'b0001;
          6'b100000:           ALU_Control = 4'b0010;
          6'b100010:           ALU_Control = 4'b0110;
          6'b100111:           ALU_Control = 4'b1100;
          6'b100110:           ALU_Control = 4'b0100;
          6'b101010:           ALU_Control = 4'b0111;
          6'b000000:           ALU_Control = 4'b1000;
          6'b000010:           ALU_Control = 4'b1001;
          6'b000011:           ALU_Control = 4'b1010;
          6'b011000, 6'b011001: ALU_Control = 4'b0101;
          6'b011010, 6'b011011: ALU_Control = 4'b1011;
          default:             ALU_Control = 4'b0000;
        endcase
      end
      default: ALU_Control = 4'b0000;
    endcase
  end

  assign is_mul  = (ALUOp == 2'b10) && (Function[5:1] == 5'b01100);
  // done blocks re-accepting the instruction still held in the done cycle
  assign accept  = valid && (is_mul || is_div) && !done && (state == IDLE);
  assign stall   = !reset && ((state != IDLE) || accept);

  assign uns     = Function[0];
  assign a_neg   = !uns && op_a[WIDTH-1];
  assign b_neg   = !uns && op_b[WIDTH-1];
  assign a_abs   = a_neg ? -op_a : op_a;
  assign b_abs   = b_neg ? -op_b : op_b;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign prod    = res_neg ? -acc : acc;

`ifdef ALU_CTRL_MDU_DIV_EN
  logic             op_div, dz, rem_neg, quo_bit;
  logic [WIDTH:0]   rem_try;
  logic [WIDTH-1:0] rem_sub, dividend, quo, rem;

  assign is_div  = (ALUOp == 2'b10) && (Function[5:1] == 5'b01101);
  // acc holds {partial remainder, remaining dividend bits / quotient bits}
  assign rem_try = acc[2*WIDTH-1:WIDTH-1];
  assign quo_bit = (rem_try >= {1'b0, b_mag});
  assign rem_sub = rem_try[WIDTH-1:0] - b_mag;
  assign quo     = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem     = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (accept) begin
      op_div   <= is_div;
      dz       <= (op_b == '0);
      rem_neg  <= a_neg;
      dividend <= op_a;
    end
  end
`else
  assign is_div = 1'b0;
`endif

  always_comb begin
    acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    res_hi  = prod[2*WIDTH-1:WIDTH];
    res_lo  = prod[WIDTH-1:0];
    res_dz  = 1'b0;
`ifdef ALU_CTRL_MDU_DIV_EN
    if (op_div) begin
      acc_nxt = {(quo_bit ? rem_sub : rem_try[WIDTH-1:0]), acc[WIDTH-2:0], quo_bit};
      if (dz) begin
        res_hi = dividend;
        res_lo = '1;
        res_dz = 1'b1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc     <= {{WIDTH{1'b0}}, a_abs};
      b_mag   <= b_abs;
      res_neg <= a_neg ^ b_neg;
      cnt     <= '0;
    end else if (state == RUN) begin
      acc     <= acc_nxt;
      cnt     <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH-1)) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= (state == SIGN);
      div_by_zero <= (state == SIGN) && res_dz;
      if (state == SIGN) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_mdu.sv
`default_nettype none
// tb_alu_ctrl_mdu: scoreboard bench; randomized MDU ops checked against a 64-bit arithmetic model.
module tb_alu_ctrl_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   ALUOp;
  logic [5:0]   Function;
  logic         valid;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   ALU_Control;
  logic         stall;
  logic [W-1:0] hi, lo;
  logic         done, div_by_zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;
  exp_t sbq[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;

  alu_ctrl_mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .Function(Function), .valid(valid),
    .op_a(op_a), .op_b(op_b), .ALU_Control(ALU_Control), .stall(stall),
    .hi(hi), .lo(lo), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] dec(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b00: return 4'b0010;
      2'b01: return 4'b0110;
      2'b11: return 4'b0000;
      default: begin
        case (f)
          6'b100101: return 4'b0001;
          6'b100000: return 4'b0010;
          6'b100010: return 4'b0110;
          6'b100111: return 4'b1100;
          6'b100110: return 4'b0100;
          6'b101010: return 4'b0111;
          6'b000000: return 4'b1000;
          6'b000010: return 4'b1001;
          6'b000011: return 4'b1010;
          6'b011000, 6'b011001: return 4'b0101;
          6'b011010, 6'b011011: return 4'b1011;
          default: return 4'b0000;
        endcase
      end
    endcase
  endfunction

  function automatic bit accepts(input logic [5:0] f);
`ifdef ALU_CTRL_MDU_DIV_EN
    return (f[5:1] == 5'b01100) || (f[5:1] == 5'b01101);
`else
    return (f[5:1] == 5'b01100);
`endif
  endfunction

  // Reference results from plain 64-bit arithmetic
  function automatic void model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    edz = 1'b0;
    case (f[1:0])
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 0) begin
          p   = {a, 32'hFFFF_FFFF};
          edz = 1'b1;
        end else if (f[0]) begin
          p = {a % b, a / b};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    eh = p[63:32];
    el = p[31:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: cycle %0d with no result pending", cyc);
      end else begin
        e = sbq.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.due));
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dz));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after done
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit wiggle, input bit release_after, output int done_at);
    exp_t e;
    int stalls;
    bit seen;
    ALUOp = 2'b10; Function = f; valid = 1'b1; op_a = a; op_b = b;
    model(f, a, b, e.hi, e.lo, e.dz);
    e.due = cyc + W + 2;
    sbq.push_back(e);
    m_hi = e.hi; m_lo = e.lo;
    stalls = 0; seen = 1'b0; done_at = -1;
    for (int k = 0; k < W + 10; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        done_at = cyc;
        check("stall_in_done", 64'(stall), 64'(0));
        break;
      end
      if (stall) stalls++;
      @(posedge clk); #1;
      if (wiggle && k < W - 1) begin
        op_a = $urandom; op_b = $urandom; valid = 1'($urandom_range(0, 1));
      end else begin
        valid = 1'b1;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL mdu_timeout: no done within %0d cycles", W + 10);
      void'(sbq.pop_back());
    end
    check("stall_len", 64'(stalls), 64'(W + 2));
    @(posedge clk); #1;
    if (release_after) valid = 1'b0;
  endtask

  task automatic run_noop(input logic [1:0] op, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUOp = op; Function = f; valid = 1'b1; op_a = a; op_b = b;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("noop_stall", 64'(stall), 64'(0));
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check("noop_hi", 64'(hi), 64'(m_hi));
    check("noop_lo", 64'(lo), 64'(m_lo));
  endtask

  task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input bit wiggle);
    int d;
    if (accepts(f)) run_op(f, a, b, wiggle, 1'b1, d);
    else            run_noop(2'b10, f, a, b);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2;
    reset = 1'b1; valid = 1'b0; ALUOp = 2'b00; Function = 6'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 64; f++) begin
        @(posedge clk); #1;
        ALUOp = 2'(op); Function = 6'(f);
        @(negedge clk);
        check("alu_control", 64'(ALU_Control), 64'(dec(2'(op), 6'(f))));
        check("sweep_stall", 64'(stall), 64'(0));
      end
    end
    @(posedge clk); #1;

    do_op(6'b011000, 32'hFFFF_FFFD, 32'd5, 1'b0);
    do_op(6'b011001, 32'hFFFF_FFFD, 32'd5, 1'b0);
    do_op(6'b011010, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(6'b011011, 32'd7, 32'd2, 1'b0);
    do_op(6'b011010, 32'h0000_1234, 32'd0, 1'b0);
    do_op(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    run_op(6'b011000, 32'd1234, 32'hFFFF_0001, 1'b0, 1'b0, d1);
    run_op(6'b011001, 32'hDEAD_BEEF, 32'h0000_1001, 1'b0, 1'b1, d2);
    check("b2b_spacing", 64'(d2 - d1), 64'(W + 3));

    for (int i = 0; i < 20; i++)
      do_op({4'b0110, 2'($urandom_range(0, 3))}, pick(), pick(), 1'($urandom_range(0, 1)));

    run_noop(2'b00, 6'b011000, $urandom, $urandom);
    run_noop(2'b11, 6'b011010, $urandom, $urandom);
    run_noop(2'b10, 6'b100000, $urandom, $urandom);

    do_op(6'b011000, 32'd7, 32'd9, 1'b0);
    ALUOp = 2'b10; Function = 6'b011000; valid = 1'b1; op_a = 32'd11; op_b = 32'd13;
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk);
    check("run_stall", 64'(stall), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1; valid = 1'b0;
    @(negedge clk);
    check("stall_in_reset", 64'(stall), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    check("post_rst_stall", 64'(stall), 64'(0));
    check("post_rst_hi", 64'(hi), 64'(0));
    check("post_rst_lo", 64'(lo), 64'(0));
    check("post_rst_done", 64'(done), 64'(0));
    repeat (W + 5) @(negedge clk);
    check("post_rst_lo_hold", 64'(lo), 64'(0));

    @(posedge clk); #1;
    do_op(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(sbq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
